// File: rtl/poci_keys_subsystem.sv
// POCI subsystem: address decoder (slave 0 = keys/switches, slave 1 exported) plus KEY/SW peripheral.
// Optional key-press edge capture, MASK register and irq are built when POCI_KEYS_EDGE_CAPTURE_EN is defined.
module poci_keys_subsystem (
  input  logic        pclk,
  input  logic        preset,
  input  logic [31:0] m_paddr,
  input  logic        m_pwrite,
  input  logic        m_psel,
  input  logic        m_penable,
  input  logic [31:0] m_pwdata,
  output logic [31:0] m_prdata,
  output logic [31:0] s1_paddr,
  output logic [31:0] s1_pwdata,
  output logic        s1_pwrite,
  output logic        s1_penable,
  output logic        s1_psel,
  input  logic [31:0] s1_prdata,
  input  logic [3:0]  key,
  input  logic [9:0]  sw,
  output logic        irq
);

  // Transfer handshake: psel alone is the setup phase, psel & penable is the access
  // phase; there are no wait states, so every access phase completes on the next
  // rising edge and a write (pwrite = 1) commits on exactly that edge.
  logic        hit0;
  logic        hit1;
  logic        s0_sel;
  logic [31:0] s0_rdata;
  logic [3:0]  key_s1;
  logic [3:0]  key_s;
  logic [9:0]  sw_s1;
  logic [9:0]  sw_s;
  logic [3:0]  edge_q;
  logic [3:0]  mask_q;

  assign hit0   = (m_paddr[31:12] == 20'h40000);
  assign hit1   = (m_paddr[31:12] == 20'h40001);
  assign s0_sel = m_psel & hit0;

  assign s1_psel    = m_psel & hit1;
  assign s1_paddr   = m_paddr;
  assign s1_pwdata  = m_pwdata;
  assign s1_pwrite  = m_pwrite;
  assign s1_penable = m_penable;

  // Keys reset to released (all ones) so no press is seen coming out of reset.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      key_s1 <= 4'hF;
      key_s  <= 4'hF;
      sw_s1  <= 10'h000;
      sw_s   <= 10'h000;
    end else begin
      key_s1 <= key;
      key_s  <= key_s1;
      sw_s1  <= sw;
      sw_s   <= sw_s1;
    end
  end

`ifdef POCI_KEYS_EDGE_CAPTURE_EN
  logic       s0_wr;
  logic [3:0] key_d3;
  logic [3:0] edge_clr;
  logic       irq_q;

  assign s0_wr    = s0_sel & m_penable & m_pwrite;
  assign edge_clr = (s0_wr && m_paddr[3:2] == 2'd2) ? m_pwdata[3:0] : 4'h0;

  // A newly detected press is OR-ed in after the clear, so set beats W1C.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      key_d3 <= 4'hF;
      edge_q <= 4'h0;
      mask_q <= 4'h0;
      irq_q  <= 1'b0;
    end else begin
      key_d3 <= key_s;
      edge_q <= (edge_q & ~edge_clr) | (key_d3 & ~key_s);
      if (s0_wr && m_paddr[3:2] == 2'd3) begin
        mask_q <= m_pwdata[3:0];
      end
      irq_q  <= |(edge_q & mask_q);
    end
  end

  assign irq = irq_q;
`else
  assign edge_q = 4'h0;
  assign mask_q = 4'h0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    s0_rdata = 32'h0;
    case (m_paddr[3:2])
      2'd0:    s0_rdata = {28'b0, key_s};
      2'd1:    s0_rdata = {22'b0, sw_s};
      2'd2:    s0_rdata = {28'b0, edge_q};
      default: s0_rdata = {28'b0, mask_q};
    endcase
  end

  always_comb begin
    m_prdata = 32'h0;
    if (s0_sel) begin
      m_prdata = s0_rdata;
    end else if (s1_psel) begin
      m_prdata = s1_prdata;
    end
  end

endmodule

// File: tb/tb_poci_keys_subsystem.sv
// Self-checking bench for poci_keys_subsystem: directed test-plan steps, then random
// traffic, checked every cycle against a pin-history model of the peripheral.
module tb_poci_keys_subsystem;

`ifdef POCI_KEYS_EDGE_CAPTURE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  localparam int HIST = 16384;

  logic        pclk;
  logic        preset;
  logic [31:0] m_paddr;
  logic        m_pwrite;
  logic        m_psel;
  logic        m_penable;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;
  logic [31:0] s1_paddr;
  logic [31:0] s1_pwdata;
  logic        s1_pwrite;
  logic        s1_penable;
  logic        s1_psel;
  logic [31:0] s1_prdata;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  poci_keys_subsystem dut (
    .pclk(pclk), .preset(preset),
    .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .s1_paddr(s1_paddr), .s1_pwdata(s1_pwdata), .s1_pwrite(s1_pwrite),
    .s1_penable(s1_penable), .s1_psel(s1_psel), .s1_prdata(s1_prdata),
    .key(key), .sw(sw), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin values as seen at each rising edge since reset; pins before reset count as idle.
  logic [3:0] key_samp[HIST];
  logic [9:0] sw_samp[HIST];
  int         cyc;
  logic [3:0] edge_m;
  logic [3:0] mask_m;
  logic       irq_m;

  function automatic logic [3:0] key_at(input int c);
    if (c < 0) return 4'hF;
    return key_samp[c];
  endfunction

  function automatic logic [9:0] sw_at(input int c);
    if (c < 0) return 10'h000;
    return sw_samp[c];
  endfunction

  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      cyc    = 0;
      edge_m = 4'h0;
      mask_m = 4'h0;
      irq_m  = 1'b0;
    end else begin
      logic [3:0] press;
      logic [3:0] clr;
      logic [3:0] new_mask;
      if (cyc < HIST) begin
        key_samp[cyc] = key;
        sw_samp[cyc]  = sw;
      end
      // A press is a pin sampled high then low, judged once the low sample is 2 edges old.
      press    = key_at(cyc - 3) & ~key_at(cyc - 2);
      clr      = 4'h0;
      new_mask = mask_m;
      if (m_psel && m_penable && m_pwrite && m_paddr[31:12] == 20'h40000) begin
        if (m_paddr[3:2] == 2'd2) clr = m_pwdata[3:0];
        if (m_paddr[3:2] == 2'd3) new_mask = m_pwdata[3:0];
      end
      irq_m  = EDGE_EN && ((edge_m & mask_m) != 4'h0);
      edge_m = (edge_m & ~clr) | press;
      mask_m = new_mask;
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge pclk) begin
    logic [31:0] exp_rd;
    logic        exp_s1sel;
    exp_rd    = 32'h0;
    exp_s1sel = m_psel && (m_paddr[31:12] == 20'h40001);
    if (m_psel && m_paddr[31:12] == 20'h40000) begin
      case (m_paddr[3:2])
        2'd0:    exp_rd = {28'b0, key_at(cyc - 2)};
        2'd1:    exp_rd = {22'b0, sw_at(cyc - 2)};
        2'd2:    exp_rd = EDGE_EN ? {28'b0, edge_m} : 32'h0;
        default: exp_rd = EDGE_EN ? {28'b0, mask_m} : 32'h0;
      endcase
    end else if (exp_s1sel) begin
      exp_rd = s1_prdata;
    end
    check("m_prdata", m_prdata, exp_rd);
    check("irq", {31'b0, irq}, {31'b0, irq_m});
    check("s1_psel", {31'b0, s1_psel}, {31'b0, exp_s1sel});
    check("s1_paddr", s1_paddr, m_paddr);
    check("s1_pwdata", s1_pwdata, m_pwdata);
    check("s1_ctl", {30'b0, s1_pwrite, s1_penable}, {30'b0, m_pwrite, m_penable});
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #2;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge pclk); #2;
    m_paddr = addr; m_pwdata = data; m_pwrite = 1'b1; m_psel = 1'b1; m_penable = 1'b0;
    @(posedge pclk); #2;
    m_penable = 1'b1;
    @(posedge pclk); #2;
    m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, input bit pin, input string name);
    @(posedge pclk); #2;
    m_paddr = addr; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    @(posedge pclk); #2;
    m_penable = 1'b1;
    @(negedge pclk);
    if (pin) check(name, m_prdata, exp_q.pop_front());
    @(posedge pclk); #2;
    m_psel = 1'b0; m_penable = 1'b0;
  endtask

  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    apb_read(addr, 1'b1, name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    preset = 1'b1; key = 4'hF; sw = 10'h000;
    m_paddr = 32'h0; m_pwrite = 1'b0; m_psel = 1'b0; m_penable = 1'b0; m_pwdata = 32'h0;
    s1_prdata = 32'h0;

    // Reset state
    repeat (2) @(negedge pclk);
    check("rst_prdata", m_prdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_s1_psel", {31'b0, s1_psel}, 32'h0);
    @(posedge pclk); #2;
    preset = 1'b0;
    read_check(32'h4000_0000, 32'h0000_000F, "rst_key");
    read_check(32'h4000_0004, 32'h0000_0000, "rst_sw");

    // Synchronized pin levels
    @(posedge pclk); #2;
    sw = 10'h2A5; key = 4'b1010;
    idle(3);
    read_check(32'h4000_0004, 32'h0000_02A5, "sw_level");
    read_check(32'h4000_0000, 32'h0000_000A, "key_level");
    read_check(32'h4000_0FF0, 32'h0000_000A, "key_alias");

    // Slave-1 pass-through write and read
    @(posedge pclk); #2;
    m_paddr = 32'h4000_1000; m_pwdata = 32'h1234_5678; m_pwrite = 1'b1; m_psel = 1'b1;
    @(negedge pclk);
    check("s1_setup_psel", {31'b0, s1_psel}, 32'h1);
    @(posedge pclk); #2;
    m_penable = 1'b1;
    @(negedge pclk);
    check("s1_access_psel", {31'b0, s1_psel}, 32'h1);
    check("s1_wdata", s1_pwdata, 32'h1234_5678);
    check("s1_wr", {31'b0, s1_pwrite}, 32'h1);
    @(posedge pclk); #2;
    m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
    s1_prdata = 32'hCAFE_F00D;
    read_check(32'h4000_1000, 32'hCAFE_F00D, "s1_read");

    // Unmapped
    @(posedge pclk); #2;
    m_paddr = 32'h3000_0000; m_psel = 1'b0;
    @(negedge pclk);
    check("unmapped_nosel", m_prdata, 32'h0);
    @(posedge pclk); #2;
    m_paddr = 32'h4000_2000; m_psel = 1'b1;
    @(negedge pclk);
    check("unmapped_sel", m_prdata, 32'h0);
    check("unmapped_s1_psel", {31'b0, s1_psel}, 32'h0);
    @(posedge pclk); #2;
    m_psel = 1'b0;
    apb_write(32'h4000_2000, 32'hFFFF_FFFF);

`ifdef POCI_KEYS_EDGE_CAPTURE_EN
    // Edge capture and interrupt
    key = 4'hF;
    idle(4);
    apb_write(32'h4000_0008, 32'h0000_000F);
    apb_write(32'h4000_000C, 32'hFFFF_FFF4);
    read_check(32'h4000_000C, 32'h0000_0004, "mask_rd");
    key = 4'b1011;
    idle(5);
    key = 4'hF;
    @(negedge pclk);
    check("irq_on", {31'b0, irq}, 32'h1);
    read_check(32'h4000_0008, 32'h0000_0004, "edge_k2");
    apb_write(32'h4000_0008, 32'h0000_0004);
    @(negedge pclk);
    check("irq_hold", {31'b0, irq}, 32'h1);
    @(negedge pclk);
    check("irq_off", {31'b0, irq}, 32'h0);
    read_check(32'h4000_0008, 32'h0000_0000, "edge_clr");
    key = 4'b1101;
    idle(5);
    key = 4'hF;
    idle(5);
    read_check(32'h4000_0008, 32'h0000_0002, "edge_k1");
    check("irq_masked", {31'b0, irq}, 32'h0);

    // Press detected on the same edge as a W1C of that bit
    apb_write(32'h4000_0008, 32'h0000_000F);
    idle(1);
    key = 4'b1110;
    @(posedge pclk); #2;
    m_paddr = 32'h4000_0008; m_pwdata = 32'h1; m_pwrite = 1'b1; m_psel = 1'b1; m_penable = 1'b0;
    @(posedge pclk); #2;
    m_penable = 1'b1;
    @(posedge pclk); #2;
    m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
    key = 4'hF;
    read_check(32'h4000_0008, 32'h0000_0001, "edge_set_wins");
`endif

    // Random traffic, with one reset landing mid-transfer
    for (int i = 0; i < 400; i++) begin
      logic [31:0] addr;
      int          sel;
      if (i == 200) begin
        @(posedge pclk); #2;
        m_paddr = 32'h4000_000C; m_pwdata = 32'h0000_000F; m_pwrite = 1'b1; m_psel = 1'b1;
        @(posedge pclk); #2;
        m_penable = 1'b1;
        #1 preset = 1'b1;
        @(posedge pclk); #2;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
        @(posedge pclk); #2;
        preset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) key = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) sw = 10'($urandom_range(0, 1023));
      s1_prdata = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: addr = {20'h40000, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         2'($urandom_range(0, 3)), 2'b00};
        3:       addr = {20'h40001, 12'($urandom_range(0, 4095))};
        4:       addr = {20'h40000, 8'h00, 2'd2, 2'b00};
        default: addr = $urandom;
      endcase
      if ($urandom_range(0, 1) == 0) apb_write(addr, $urandom);
      else apb_read(addr, 1'b0, "rand_read");
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
